// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NOT) between
// two valid/ready requesters, with a single tagged response channel.
//
// state | meaning
// IDLE  | waiting for a grant; captures op/operands/id on accept
// EXEC  | computes the result from captured values into response registers
// RESP  | holds the response until resp_ready, then counts it and rotates priority
module logic16_arbiter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [1:0]       req_op1,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  logic [1:0]       grant;
  logic             prio;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic [WIDTH-1:0] alu;

  // prio names the requester that wins when both are valid
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Masked while rst_n is low so nothing looks accepted during reset.
  assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
  assign busy      = (state != IDLE);

  always_comb begin
    alu = '0;
    case (op_q)
      2'b00:   alu = a_q & b_q;
      2'b01:   alu = a_q | b_q;
      2'b10:   alu = a_q ^ b_q;
      default: alu = ~a_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      prio       <= 1'b0;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant[0]) begin
            op_q  <= req_op0;
            a_q   <= req_a0;
            b_q   <= req_b0;
            id_q  <= 1'b0;
            state <= EXEC;
          end else if (grant[1]) begin
            op_q  <= req_op1;
            a_q   <= req_a1;
            b_q   <= req_b1;
            id_q  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          resp_data  <= alu;
          resp_id    <= id_q;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            done_cnt   <= done_cnt + CNT_W'(1);
            prio       <= ~resp_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic16_arbiter.sv
// Directed self-checking bench for logic16_arbiter with hand-computed results.
module tb_logic16_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_op0, req_op1;
  logic [15:0] req_a0, req_b0, req_a1, req_b1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [15:0] resp_data;
  logic        busy;
  logic [15:0] done_cnt;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;

  always #5 clk = ~clk;

  logic16_arbiter #(.WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_a0(req_a0), .req_b0(req_b0),
    .req_op1(req_op1), .req_a1(req_a1), .req_b1(req_b1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data),
    .busy(busy), .done_cnt(done_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expects an accept in the current cycle, then checks EXEC, response and handshake.
  task automatic run_op(input string tag, input logic [1:0] exp_grant,
                        input logic exp_id, input logic [15:0] exp_data);
    check({tag, ".ready"}, 32'(req_ready), 32'(exp_grant));
    cyc();
    check({tag, ".exec_busy"}, 32'(busy), 32'd1);
    check({tag, ".exec_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".exec_ready"}, 32'(req_ready), 32'd0);
    cyc();
    check({tag, ".valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".data"}, 32'(resp_data), 32'(exp_data));
    check({tag, ".id"}, 32'(resp_id), 32'(exp_id));
    cyc();
    exp_done++;
    check({tag, ".hs_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".cnt"}, 32'(done_cnt), 32'(exp_done));
    check({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; resp_ready = 1'b0;
    req_op0 = 2'b00; req_a0 = 16'h0; req_b0 = 16'h0;
    req_op1 = 2'b00; req_a1 = 16'h0; req_b1 = 16'h0;

    // reset with both requesters asserting
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("rst.ready", 32'(req_ready), 32'd0);
      check("rst.valid", 32'(resp_valid), 32'd0);
      check("rst.data", 32'(resp_data), 32'd0);
      check("rst.cnt", 32'(done_cnt), 32'd0);
      check("rst.busy", 32'(busy), 32'd0);
    end
    rst_n = 1'b1; req_valid = 2'b00;
    cyc();

    // single OR from requester 0
    resp_ready = 1'b1;
    req_valid = 2'b01; req_op0 = 2'b01; req_a0 = 16'hAAAA; req_b0 = 16'h5555;
    #1;
    check("or.ready", 32'(req_ready), 32'd1);
    cyc();
    req_valid = 2'b00;
    check("or.exec_busy", 32'(busy), 32'd1);
    cyc();
    check("or.valid", 32'(resp_valid), 32'd1);
    check("or.data", 32'(resp_data), 32'hFFFF);
    check("or.id", 32'(resp_id), 32'd0);
    cyc();
    exp_done++;
    check("or.cnt", 32'(done_cnt), 32'(exp_done));

    // every opcode from requester 1
    req_a1 = 16'h3CC3; req_b1 = 16'h0FF0;
    req_op1 = 2'b00; req_valid = 2'b10; #1; run_op("and1", 2'b10, 1'b1, 16'h0CC0);
    req_op1 = 2'b01; #1; run_op("or1",  2'b10, 1'b1, 16'h3FF3);
    req_op1 = 2'b10; #1; run_op("xor1", 2'b10, 1'b1, 16'h3333);
    req_op1 = 2'b11; #1; run_op("not1", 2'b10, 1'b1, 16'hC33C);
    req_valid = 2'b00;
    cyc();

    // contention: priority rotates after each handshake
    req_op0 = 2'b00; req_a0 = 16'h1234; req_b0 = 16'h9876;
    req_op1 = 2'b10; req_a1 = 16'h1234; req_b1 = 16'h9876;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) run_op("cont0", 2'b01, 1'b0, 16'h1034);
      else            run_op("cont1", 2'b10, 1'b1, 16'h8A42);
    end
    req_valid = 2'b00;
    cyc();

    // backpressure with operand changes after accept
    resp_ready = 1'b0;
    req_valid = 2'b01; req_op0 = 2'b10; req_a0 = 16'hFF00; req_b0 = 16'h0F0F;
    #1;
    check("bp.ready", 32'(req_ready), 32'd1);
    cyc();
    req_a0 = 16'h1111; req_op0 = 2'b11;
    cyc();
    for (int i = 0; i < 5; i++) begin
      req_a0 = req_a0 + 16'h0101;
      cyc();
      check("bp.data", 32'(resp_data), 32'hF00F);
      check("bp.valid", 32'(resp_valid), 32'd1);
      check("bp.ready_blk", 32'(req_ready), 32'd0);
      check("bp.busy", 32'(busy), 32'd1);
      check("bp.cnt_hold", 32'(done_cnt), 32'(exp_done));
    end
    req_valid = 2'b00;
    resp_ready = 1'b1;
    cyc();
    exp_done++;
    check("bp.hs_valid", 32'(resp_valid), 32'd0);
    check("bp.cnt", 32'(done_cnt), 32'(exp_done));
    cyc();
    check("bp.no_extra", 32'(done_cnt), 32'(exp_done));

    // reset in EXEC; requester 1 holds priority going in
    req_op0 = 2'b01; req_a0 = 16'h00F0; req_b0 = 16'h0F00;
    req_op1 = 2'b00; req_a1 = 16'hFFFF; req_b1 = 16'h1234;
    req_valid = 2'b11;
    #1;
    check("mid.ready_pre", 32'(req_ready), 32'd2);
    cyc();
    check("mid.exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    exp_done = 0;
    #1;
    check("mid.valid", 32'(resp_valid), 32'd0);
    check("mid.busy", 32'(busy), 32'd0);
    check("mid.cnt", 32'(done_cnt), 32'd0);
    run_op("mid.after", 2'b01, 1'b0, 16'h0FF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
